// File: rtl/rob_commit_ctrl_pkg.sv
// LC-3b shared types for the retirement slice: opcodes, register index,
// commit FSM states and opcode classification helpers used by decode,
// dispatch and commit.
package rob_commit_ctrl_pkg;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ST_WAIT = 2'd1,
        FLUSH   = 2'd2
    } rob_commit_state_t;

    localparam lc3b_reg LINK_REG = 3'd7;

    // Opcodes that write the architectural register file on retirement.
    // JSR/TRAP write the link register R7.
    function automatic logic is_reg_write(input lc3b_opcode op);
        case (op)
            op_add, op_and, op_not, op_shf, op_lea,
            op_ldr, op_ldb, op_ldi, op_jsr, op_trap: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    // Opcodes whose memory write happens at commit through the store queue.
    function automatic logic is_store(input lc3b_opcode op);
        case (op)
            op_stb, op_str, op_sti: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Commit-side bundle between the ROB head, the commit controller, the
// architectural register file, the store queue and fetch.
interface rob_commit_ctrl_if
    import rob_commit_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             rob_empty;
    logic             head_valid;
    logic [2:0]       head_addr;
    lc3b_opcode       head_inst;
    lc3b_reg          head_dest;
    logic [15:0]      head_value;
    logic             head_predict;
    logic             RE;
    logic             flush;
    logic             regfile_ld;
    lc3b_reg          regfile_dest;
    logic [15:0]      regfile_data;
    logic [2:0]       regfile_tag;
    logic             st_commit;
    logic             st_done;
    logic             redirect;
    logic             redirect_taken;
    logic [CNT_W-1:0] retire_count;

    // ROB / store queue / fetch side
    modport master (
        output rob_empty, head_valid, head_addr, head_inst, head_dest,
               head_value, head_predict, st_done,
        input  RE, flush, regfile_ld, regfile_dest, regfile_data,
               regfile_tag, st_commit, redirect, redirect_taken, retire_count
    );

    // Commit controller side
    modport slave (
        input  rob_empty, head_valid, head_addr, head_inst, head_dest,
               head_value, head_predict, st_done,
        output RE, flush, regfile_ld, regfile_dest, regfile_data,
               regfile_tag, st_commit, redirect, redirect_taken, retire_count
    );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order retirement controller for the 8-entry ROB. Commit decisions are
// combinational on the head so an instruction retires in the cycle its
// result is seen; stores handshake with the store queue and mispredicted
// branches flush the machine and hold commit off while it drains.
module rob_commit_ctrl
    import rob_commit_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rob_commit_ctrl_if.slave        bus
);

    rob_commit_state_t state, state_nxt;
    logic [2:0]        flush_cnt;
    logic [CNT_W-1:0]  retire_cnt;

    logic    re, flush, rf_ld, st_commit, redirect, redirect_taken;
    lc3b_reg rf_dest;
    logic [15:0] rf_data;
    logic [2:0]  rf_tag;
    logic        head_ready, mispredict;

    // Gate on rst_n so no strobe escapes while reset is asserted.
    assign head_ready = rst_n && !bus.rob_empty && bus.head_valid;
    assign mispredict = bus.head_value[0] != bus.head_predict;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Next state and same-cycle commit strobes.
    always_comb begin
        state_nxt      = state;
        re             = 1'b0;
        flush          = 1'b0;
        rf_ld          = 1'b0;
        rf_dest        = '0;
        rf_data        = '0;
        rf_tag         = '0;
        st_commit      = 1'b0;
        redirect       = 1'b0;
        redirect_taken = 1'b0;
        case (state)
            RUN: begin
                if (head_ready) begin
                    if (is_reg_write(bus.head_inst)) begin
                        re      = 1'b1;
                        rf_ld   = 1'b1;
                        rf_dest = (bus.head_inst == op_jsr || bus.head_inst == op_trap)
                                  ? LINK_REG : bus.head_dest;
                        rf_data = bus.head_value;
                        rf_tag  = bus.head_addr;
                    end else if (is_store(bus.head_inst)) begin
                        st_commit = 1'b1;
                        state_nxt = ST_WAIT;
                    end else if (bus.head_inst == op_br && mispredict) begin
                        // The flush itself removes the head; no RE.
                        flush          = 1'b1;
                        redirect       = 1'b1;
                        redirect_taken = bus.head_value[0];
                        state_nxt      = FLUSH;
                    end else begin
                        re = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.st_done) begin
                    re        = 1'b1;
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                if (flush_cnt <= 3'd1) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Drain counter: loaded on the flush pulse, counts down while in FLUSH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              flush_cnt <= '0;
        else if (flush)          flush_cnt <= 3'(FLUSH_CYCLES);
        else if (state == FLUSH) flush_cnt <= flush_cnt - 3'd1;
    end

    // Retired-instruction counter; a mispredicted branch retires via flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          retire_cnt <= '0;
        else if (re | flush) retire_cnt <= retire_cnt + CNT_W'(1);
    end

    assign bus.RE             = re;
    assign bus.flush          = flush;
    assign bus.regfile_ld     = rf_ld;
    assign bus.regfile_dest   = rf_dest;
    assign bus.regfile_data   = rf_data;
    assign bus.regfile_tag    = rf_tag;
    assign bus.st_commit      = st_commit;
    assign bus.redirect       = redirect;
    assign bus.redirect_taken = redirect_taken;
    assign bus.retire_count   = retire_cnt;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: table of single-cycle head
// vectors plus hand sequences for store, mispredict, reset and wrap.
module tb_rob_commit_ctrl;
    import rob_commit_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_commit_ctrl_if #(.CNT_W(16)) bus ();

    rob_commit_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        empty;
        logic        valid;
        logic [2:0]  addr;
        lc3b_opcode  inst;
        logic [2:0]  dest;
        logic [15:0] value;
        logic        pred;
        logic        st_done;
        logic        e_re;
        logic        e_ld;
        logic [2:0]  e_dest;
        logic [15:0] e_data;
        logic [2:0]  e_tag;
        logic        e_st;
        logic        e_flush;
        logic        e_redir;
        logic        e_taken;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] model_cnt = '0;
    logic [15:0] sb_q[$];
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.rob_empty    = v.empty;
        bus.head_valid   = v.valid;
        bus.head_addr    = v.addr;
        bus.head_inst    = v.inst;
        bus.head_dest    = v.dest;
        bus.head_value   = v.value;
        bus.head_predict = v.pred;
        bus.st_done      = v.st_done;
    endtask

    // Drive one cycle (called at posedge+1), check strobes mid-cycle and the
    // counter after the edge via the scoreboard queue.
    task automatic step(input vec_t v, input string nm);
        drive(v);
        @(negedge clk);
        chk({nm, " RE"},        32'(bus.RE),             32'(v.e_re));
        chk({nm, " ld"},        32'(bus.regfile_ld),     32'(v.e_ld));
        chk({nm, " dest"},      32'(bus.regfile_dest),   32'(v.e_dest));
        chk({nm, " data"},      32'(bus.regfile_data),   32'(v.e_data));
        chk({nm, " tag"},       32'(bus.regfile_tag),    32'(v.e_tag));
        chk({nm, " st_commit"}, 32'(bus.st_commit),      32'(v.e_st));
        chk({nm, " flush"},     32'(bus.flush),          32'(v.e_flush));
        chk({nm, " redirect"},  32'(bus.redirect),       32'(v.e_redir));
        chk({nm, " taken"},     32'(bus.redirect_taken), 32'(v.e_taken));
        if (v.e_re || v.e_flush) model_cnt = model_cnt + 16'd1;
        sb_q.push_back(model_cnt);
        @(posedge clk); #1;
        chk({nm, " count"}, 32'(bus.retire_count), 32'(sb_q.pop_front()));
    endtask

    // Simple vector builders.
    function automatic vec_t idle(input logic empty, input logic valid, input lc3b_opcode op);
        vec_t v = '{empty, valid, 3'd0, op, 3'd1, 16'h0001, 1'b0, 1'b0,
                    1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        return v;
    endfunction

    function automatic vec_t wr(input lc3b_opcode op, input logic [2:0] a,
                                input logic [2:0] d, input logic [15:0] val,
                                input logic [2:0] ed);
        vec_t v = '{1'b0, 1'b1, a, op, d, val, 1'b0, 1'b0,
                    1'b1, 1'b1, ed, val, a, 1'b0, 1'b0, 1'b0, 1'b0};
        return v;
    endfunction

    function automatic vec_t re_only(input lc3b_opcode op, input logic pred, input logic [15:0] val);
        vec_t v = '{1'b0, 1'b1, 3'd4, op, 3'd2, val, pred, 1'b0,
                    1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        return v;
    endfunction

    vec_t v;

    initial begin
        drive(idle(1'b1, 1'b0, op_add));
        // Reset asserted with a ready head: no strobes may escape.
        bus.rob_empty = 1'b0; bus.head_valid = 1'b1;
        #12;
        chk("in_reset RE", 32'(bus.RE), 32'd0);
        chk("in_reset ld", 32'(bus.regfile_ld), 32'd0);
        chk("in_reset cnt", 32'(bus.retire_count), 32'd0);
        drive(idle(1'b1, 1'b0, op_add));
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) step(idle(1'b1, 1'b0, op_add), "post_reset_empty");

        // Single-cycle RUN vectors.
        tbl.push_back(wr(op_add, 3'd3, 3'd2, 16'd15, 3'd2));
        tbl.push_back(wr(op_and, 3'd0, 3'd5, 16'hA5A5, 3'd5));
        tbl.push_back(wr(op_ldr, 3'd7, 3'd0, 16'hFFFF, 3'd0));
        tbl.push_back(wr(op_shf, 3'd6, 3'd6, 16'h8001, 3'd6));
        tbl.push_back(wr(op_lea, 3'd5, 3'd4, 16'h3000, 3'd4));
        tbl.push_back(wr(op_jsr, 3'd1, 3'd3, 16'h1234, 3'd7));
        tbl.push_back(wr(op_trap, 3'd2, 3'd4, 16'h0200, 3'd7));
        tbl.push_back(re_only(op_jmp, 1'b0, 16'h4000));
        tbl.push_back(re_only(op_rti, 1'b0, 16'h0000));
        tbl.push_back(re_only(op_br, 1'b1, 16'h0001));
        tbl.push_back(re_only(op_br, 1'b0, 16'h0000));
        tbl.push_back(idle(1'b1, 1'b1, op_add));
        for (int i = 0; i < 5; i++) tbl.push_back(idle(1'b0, 1'b0, op_add));
        tbl.push_back(wr(op_add, 3'd1, 3'd1, 16'h0042, 3'd1));
        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Store: st_done in the commit cycle is ignored, then 3 waits.
        v = idle(1'b0, 1'b1, op_str); v.st_done = 1'b1; v.e_st = 1'b1;
        step(v, "st_commit");
        v = idle(1'b0, 1'b1, op_str);
        for (int i = 0; i < 3; i++) step(v, "st_wait");
        v.st_done = 1'b1; v.e_re = 1'b1;
        step(v, "st_done");
        step(wr(op_add, 3'd2, 3'd3, 16'h0007, 3'd3), "after_store");

        // Mispredict: flush pulse, then exactly 2 blocked cycles.
        v = idle(1'b0, 1'b1, op_br); v.pred = 1'b0; v.value = 16'h0001;
        v.e_flush = 1'b1; v.e_redir = 1'b1; v.e_taken = 1'b1;
        step(v, "mispredict");
        for (int i = 0; i < 2; i++) step(idle(1'b0, 1'b1, op_add), "flush_hold");
        step(wr(op_add, 3'd5, 3'd6, 16'h0099, 3'd6), "after_flush");

        // Reset in the middle of ST_WAIT.
        v = idle(1'b0, 1'b1, op_stb); v.e_st = 1'b1;
        step(v, "st2_commit");
        step(idle(1'b0, 1'b1, op_stb), "st2_wait");
        rst_n = 1'b0;
        #1;
        chk("midst_reset cnt", 32'(bus.retire_count), 32'd0);
        chk("midst_reset RE", 32'(bus.RE), 32'd0);
        model_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(wr(op_not, 3'd4, 3'd2, 16'hFF00, 3'd2), "after_reset_run");

        // Counter wrap: reset, retire 0xFFFF, then two more.
        rst_n = 1'b0;
        #1; model_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(wr(op_add, 3'd0, 3'd1, 16'h0001, 3'd1));
        repeat (65535) @(posedge clk);
        #1;
        chk("preload cnt", 32'(bus.retire_count), 32'hFFFF);
        model_cnt = 16'hFFFF;
        step(wr(op_add, 3'd0, 3'd1, 16'h0001, 3'd1), "wrap0");
        chk("wrap to 0", 32'(bus.retire_count), 32'h0000);
        step(wr(op_add, 3'd1, 3'd1, 16'h0002, 3'd1), "wrap1");
        chk("wrap to 1", 32'(bus.retire_count), 32'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
